// File: rtl/clk_div_sel_pkg.sv
// clk_div_sel_pkg: shared types and constants for the clock divider / mux select controller.
package clk_div_sel_pkg;
  typedef enum logic [1:0] {STABLE, DWELL, HOLD} sel_state_e;
  localparam int DIV_MIN = 2;
  function automatic int ctr_width(int dwell, int hold);
    int m;
    m = dwell > hold ? dwell : hold;
    return m < 2 ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter with shadowed divisor, registered divided clock and optional wrap tick.
// Optional div_tick_o output exists only when CLK_DIV_SEL_TICK_EN is defined.
module clk_div_core
  import clk_div_sel_pkg::*;
#(
  parameter int DIV_WIDTH = 8,
  parameter int DIV_RESET = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [DIV_WIDTH-1:0] div_value_i,
  input  logic                 div_load_i,
  output logic                 clk_div_o
`ifdef CLK_DIV_SEL_TICK_EN
  ,output logic                div_tick_o
`endif
);
  localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(DIV_RESET);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(DIV_MIN);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d;
  logic                 pend_q, pend_d, clk_div_q, clk_div_d, wrap;
  always_comb begin
    wrap      = cnt_q == act_q - 1'b1;
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    act_d     = wrap && pend_q ? shd_q : act_q;
    shd_d     = div_load_i ? (div_value_i < MIN_DIV ? MIN_DIV : div_value_i) : shd_q;
    // a load landing on the wrap cycle stays pending for the following period
    pend_d    = div_load_i | (pend_q & ~wrap);
    clk_div_d = cnt_d < (act_d >> 1);
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      act_q     <= RST_DIV;
      shd_q     <= RST_DIV;
      pend_q    <= 1'b0;
      clk_div_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      shd_q     <= shd_d;
      pend_q    <= pend_d;
      clk_div_q <= clk_div_d;
    end
  end
  assign clk_div_o = clk_div_q;
`ifdef CLK_DIV_SEL_TICK_EN
  logic tick_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) tick_q <= 1'b0;
    else tick_q <= wrap;
  end
  assign div_tick_o = tick_q;
`endif
endmodule

// File: rtl/clk_div_sel_ctrl.sv
// clk_div_sel_ctrl: divided-clock generator plus dwell/hold-filtered select for a glitch-free clock mux.
// Optional div_tick output exists only when CLK_DIV_SEL_TICK_EN is defined.
module clk_div_sel_ctrl
  import clk_div_sel_pkg::*;
#(
  parameter int DIV_WIDTH    = 8,
  parameter int DIV_RESET    = 2,
  parameter int DWELL_CYCLES = 4,
  parameter int HOLD_CYCLES  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 div_load,
  input  logic                 req_sel,
  output logic                 clk_div,
  output logic                 sel,
  output logic                 busy
`ifdef CLK_DIV_SEL_TICK_EN
  ,output logic                div_tick
`endif
);
  localparam int CW = ctr_width(DWELL_CYCLES, HOLD_CYCLES);
  sel_state_e    state_q, state_d;
  logic [CW-1:0] ctr_q, ctr_d;
  logic          sel_q, sel_d, busy_q;
  clk_div_core #(
    .DIV_WIDTH(DIV_WIDTH),
    .DIV_RESET(DIV_RESET)
  ) u_core (
    .clk_i      (clk),
    .reset_i    (reset),
    .div_value_i(div_value),
    .div_load_i (div_load),
    .clk_div_o  (clk_div)
`ifdef CLK_DIV_SEL_TICK_EN
    ,.div_tick_o(div_tick)
`endif
  );
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    sel_d   = sel_q;
    unique case (state_q)
      STABLE: if (req_sel != sel_q) begin
        state_d = DWELL;
        ctr_d   = CW'(DWELL_CYCLES - 1);
      end
      DWELL: if (req_sel == sel_q) state_d = STABLE;
      else if (ctr_q == '0) begin
        sel_d   = ~sel_q;
        state_d = HOLD;
        ctr_d   = CW'(HOLD_CYCLES - 1);
      end else ctr_d = ctr_q - 1'b1;
      HOLD: if (ctr_q == '0) state_d = STABLE;
      else ctr_d = ctr_q - 1'b1;
      default: state_d = STABLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STABLE;
      ctr_q   <= '0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      sel_q   <= sel_d;
      busy_q  <= state_d != STABLE;
    end
  end
  assign sel  = sel_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_clk_div_sel_ctrl.sv
// tb_clk_div_sel_ctrl: directed stimulus with a cycle-keyed expectation queue drained by a monitor.
module tb_clk_div_sel_ctrl;
  logic       clk = 1'b0, reset = 1'b1, div_load = 1'b0, req_sel = 1'b0;
  logic [7:0] div_value = '0;
  logic       clk_div, sel, busy;
`ifdef CLK_DIV_SEL_TICK_EN
  logic       div_tick;
`endif
  clk_div_sel_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .div_value(div_value),
    .div_load (div_load),
    .req_sel  (req_sel),
    .clk_div  (clk_div),
    .sel      (sel),
    .busy     (busy)
`ifdef CLK_DIV_SEL_TICK_EN
    ,.div_tick(div_tick)
`endif
  );
  always #5 clk = ~clk;
  int cyc = -3;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int    key;
    int    sig;
    logic  val;
    string nm;
  } exp_t;
  exp_t q[$];
  int   n_chk = 0, n_pass = 0;
  logic async_req = 1'b0;
  event async_ev;
  function automatic logic get(int s);
    case (s)
      0: return clk_div;
      1: return sel;
      2: return busy;
`ifdef CLK_DIV_SEL_TICK_EN
      3: return div_tick;
`endif
      default: return 1'bx;
    endcase
  endfunction
  task automatic push(int key, int s, logic v, string nm);
    exp_t e;
    int   i;
`ifndef CLK_DIV_SEL_TICK_EN
    if (s == 3) return;
`endif
    e = '{key, s, v, nm};
    i = q.size();
    while (i > 0 && q[i-1].key > key) i--;
    q.insert(i, e);
  endtask
  task automatic ex(int c, int s, logic v, string nm);
    push(2 * c, s, v, $sformatf("%s@%0d", nm, c));
  endtask
  task automatic ex_async(int c, int s, logic v, string nm);
    push(2 * c + 1, s, v, $sformatf("%s@%0d+", nm, c));
  endtask
  task automatic ex_pat(int c0, int n, logic [31:0] bits, string nm);
    for (int i = 0; i < n; i++) ex(c0 + i, 0, bits[n-1-i], nm);
  endtask
  task automatic wait_cyc(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask
  initial begin
    int   key;
    exp_t e;
    logic got;
    forever begin
      @(negedge clk or async_ev);
      key = 2 * cyc + (async_req ? 1 : 0);
      while (q.size() > 0 && q[0].key <= key) begin
        e = q.pop_front();
        n_chk++;
        got = get(e.sig);
        if (e.key < key) $display("FAIL %s: never sampled, expected %b", e.nm, e.val);
        else if (got !== e.val) $display("FAIL %s: got %b, expected %b", e.nm, got, e.val);
        else n_pass++;
      end
    end
  end
  initial begin
    wait_cyc(0);
    reset = 1'b0;
    ex(0, 1, 1'b0, "sel_rst");
    ex(0, 2, 1'b0, "busy_rst");
    ex(0, 3, 1'b0, "tick_rst");
    ex_pat(0, 7, 7'b0010101, "clkdiv_n2");
    ex(3, 1, 1'b0, "sel_idle");
    ex(5, 2, 1'b0, "busy_idle");
    wait_cyc(6);
    ex_pat(7, 12, 12'b011000110001, "clkdiv_n5");
    ex(8, 3, 1'b1, "tick_n5");
    ex(10, 3, 1'b0, "tick_n5");
    ex(13, 3, 1'b1, "tick_n5");
    ex(18, 3, 1'b1, "tick_n5");
    div_value = 8'd5;
    div_load  = 1'b1;
    wait_cyc(7);
    div_load = 1'b0;
    wait_cyc(18);
    ex_pat(19, 10, 10'b1000101010, "clkdiv_clamp");
    div_value = 8'd0;
    div_load  = 1'b1;
    wait_cyc(19);
    div_value = 8'd1;
    wait_cyc(20);
    div_load = 1'b0;
    wait_cyc(26);
    ex_pat(29, 8, 8'b11100001, "clkdiv_n7");
    ex(29, 3, 1'b1, "tick_n7");
    ex(30, 3, 1'b0, "tick_n7");
    ex(36, 3, 1'b1, "tick_n7");
    div_value = 8'd7;
    div_load  = 1'b1;
    wait_cyc(27);
    div_load = 1'b0;
    wait_cyc(39);
    ex(39, 1, 1'b0, "sel_pre");
    ex(39, 2, 1'b0, "busy_pre");
    ex(40, 2, 1'b1, "busy_dwell");
    ex(43, 1, 1'b0, "sel_dwell");
    ex(44, 1, 1'b1, "sel_rise");
    ex(51, 2, 1'b1, "busy_hold");
    ex(52, 2, 1'b0, "busy_end");
    ex(52, 1, 1'b1, "sel_hold_pulse");
    ex(55, 1, 1'b1, "sel_settled");
    ex(55, 2, 1'b0, "busy_settled");
    req_sel = 1'b1;
    wait_cyc(46);
    req_sel = 1'b0;
    wait_cyc(47);
    req_sel = 1'b1;
    wait_cyc(59);
    ex(59, 2, 1'b0, "busy_wd_pre");
    ex(60, 2, 1'b1, "busy_wd");
    ex(61, 2, 1'b1, "busy_wd");
    ex(62, 2, 1'b0, "busy_wd_end");
    ex(62, 1, 1'b1, "sel_wd");
    ex(66, 1, 1'b1, "sel_wd");
    req_sel = 1'b0;
    wait_cyc(61);
    req_sel = 1'b1;
    wait_cyc(69);
    ex(70, 2, 1'b1, "busy_fall_dwell");
    ex(73, 1, 1'b1, "sel_pre_fall");
    ex(74, 1, 1'b0, "sel_fall");
    ex(81, 2, 1'b1, "busy_hold2");
    ex(82, 2, 1'b0, "busy_gap");
    ex(83, 2, 1'b1, "busy_redwell");
    ex(86, 1, 1'b0, "sel_min_space");
    ex(87, 1, 1'b1, "sel_min_space");
    ex(91, 0, 1'b0, "clkdiv_pre_rst");
    ex(91, 1, 1'b1, "sel_pre_rst");
    ex(91, 2, 1'b1, "busy_pre_rst");
    ex(92, 0, 1'b1, "clkdiv_pre_rst");
    ex(92, 1, 1'b1, "sel_pre_rst");
    ex(92, 2, 1'b1, "busy_pre_rst");
    ex(92, 3, 1'b1, "tick_pre_rst");
    req_sel = 1'b0;
    wait_cyc(74);
    req_sel = 1'b1;
    wait_cyc(92);
    ex_async(92, 0, 1'b0, "clkdiv_async_rst");
    ex_async(92, 1, 1'b0, "sel_async_rst");
    ex_async(92, 2, 1'b0, "busy_async_rst");
    ex_async(92, 3, 1'b0, "tick_async_rst");
    #5;
    reset   = 1'b1;
    req_sel = 1'b0;
    #1 async_req = 1'b1;
    ->async_ev;
    #1 async_req = 1'b0;
    wait_cyc(94);
    reset = 1'b0;
    ex_pat(94, 5, 5'b00101, "clkdiv_restart");
    ex(94, 1, 1'b0, "sel_restart");
    ex(94, 2, 1'b0, "busy_restart");
    ex(96, 3, 1'b1, "tick_restart");
    ex(97, 3, 1'b0, "tick_restart");
    wait_cyc(99);
    ex(100, 2, 1'b1, "busy_short");
    ex(101, 2, 1'b1, "busy_short");
    ex(102, 2, 1'b0, "busy_short_end");
    ex(102, 1, 1'b0, "sel_short");
    ex(106, 1, 1'b0, "sel_short");
    req_sel = 1'b1;
    wait_cyc(101);
    req_sel = 1'b0;
    wait_cyc(110);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
